// File: rtl/trv32i_fetch_buffer.sv
// rtl/trv32i_fetch_buffer.sv - TRV32I instruction fetch stage with prefetch FIFO and redirect flush
// Optional feature: define TRV32I_FETCH_BYPASS_EN to forward a response straight to the outputs when the FIFO is empty.
module trv32i_fetch_buffer #(
    parameter int                 B_WIDTH  = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [B_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [B_WIDTH-1:0] imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [31:0]        imem_rdata,
    input  logic               redirect,
    input  logic [B_WIDTH-1:0] redirect_pc,
    output logic               inst_valid,
    output logic [31:0]        inst,
    output logic [B_WIDTH-1:0] pc,
    input  logic               inst_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW:0]        DEPTH_W = DEPTH[CW:0];
    localparam logic [B_WIDTH-1:0] PC_STEP = 4;
    localparam logic [B_WIDTH-1:0] PC_MASK = ~B_WIDTH'(3);

    logic [B_WIDTH-1:0] fetch_pc;
    logic [B_WIDTH-1:0] resp_pc;
    logic [CW-1:0]      outstanding;
    logic [CW-1:0]      discard;
    logic [CW-1:0]      count;
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [31:0]        inst_mem [DEPTH];
    logic [B_WIDTH-1:0] pc_mem   [DEPTH];

    logic [CW:0]        credit_used;
    logic [B_WIDTH-1:0] target_pc;
    logic               grant;
    logic               rsp_keep;
    logic               fifo_empty;
    logic               bypass_hit;
    logic               push;
    logic               pop;

    // Credit accounting, response classification and FIFO push/pop decisions
    always_comb begin
        credit_used = {1'b0, count} + {1'b0, outstanding};
        target_pc   = redirect_pc & PC_MASK;
        imem_req    = rst && !redirect && (credit_used < DEPTH_W);
        imem_addr   = fetch_pc;
        grant       = imem_req && imem_gnt;
        // A response is kept only when no stale words remain and we are not flushing
        rsp_keep    = imem_rvalid && (discard == '0) && !redirect;
        fifo_empty  = (count == '0);
`ifdef TRV32I_FETCH_BYPASS_EN
        bypass_hit  = rst && fifo_empty && rsp_keep;
`else
        bypass_hit  = 1'b0;
`endif
        // A bypassed word taken by the core the same cycle never enters the FIFO
        push        = rsp_keep && !(bypass_hit && inst_ready);
        pop         = !fifo_empty && inst_ready && !redirect;
    end

    // Head-of-queue presentation; outputs read as zero when nothing is valid
    always_comb begin
        inst_valid = 1'b0;
        inst       = '0;
        pc         = '0;
        if (!fifo_empty) begin
            inst_valid = 1'b1;
            inst       = inst_mem[rd_ptr];
            pc         = pc_mem[rd_ptr];
        end else if (bypass_hit) begin
            inst_valid = 1'b1;
            inst       = imem_rdata;
            pc         = resp_pc;
        end
    end

    // Fetch/response PCs, in-flight counters and FIFO pointers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (redirect) begin
            // Everything still in flight is stale, including a word landing right now
            fetch_pc    <= target_pc;
            resp_pc     <= target_pc;
            outstanding <= outstanding - CW'(imem_rvalid);
            discard     <= outstanding - CW'(imem_rvalid);
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            if (grant) begin
                fetch_pc <= fetch_pc + PC_STEP;
            end
            outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid);
            if (imem_rvalid && (discard != '0)) begin
                discard <= discard - 1'b1;
            end
            if (rsp_keep) begin
                resp_pc <= resp_pc + PC_STEP;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage holding {pc, inst} pairs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (push) begin
            inst_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]   <= resp_pc;
        end
    end

endmodule

// File: tb/tb_trv32i_fetch_buffer.sv
// tb/tb_trv32i_fetch_buffer.sv - randomized self-checking bench for trv32i_fetch_buffer
module tb_trv32i_fetch_buffer;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inst_ready = 1'b0;

    trv32i_fetch_buffer #(
        .B_WIDTH (32),
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .inst_valid (inst_valid),
        .inst       (inst),
        .pc         (pc),
        .inst_ready (inst_ready)
    );

    always #5 clk = ~clk;

    // Each granted request remembers its address and the flush epoch it belongs to
    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    req_t        pend_q[$];
    logic [31:0] fifo_q[$];
    logic [31:0] exp_fetch_pc;
    int          epoch;
    int          cyc;
    int          n_checks;
    int          n_fail;
    int          grant_cnt;
    int          n_consumed;
    int          gnt_pct, rsp_pct, rdy_pct, redir_permil, lat_min, lat_max;
    bit          req_redirect;
    logic [31:0] req_target;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1E0F} ^ (a * 32'h9E37_79B9);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_eq("rst_imem_req", {31'b0, imem_req}, 32'd0);
        check_eq("rst_imem_addr", imem_addr, RESET_PC);
        check_eq("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check_eq("rst_inst", inst, 32'd0);
        check_eq("rst_pc", pc, 32'd0);
        pend_q.delete();
        fifo_q.delete();
        epoch++;
        exp_fetch_pc = RESET_PC;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        redirect    = 1'b0;
        inst_ready  = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b1;
    endtask

    // One clock cycle: drive memory/core inputs, check outputs, advance the model
    task automatic step();
        logic        exp_req, rsp_kept, bypass, exp_valid, consumed_bypass;
        logic [31:0] head, rsp_addr;
        req_t        rsp;
        int          lat;
        imem_gnt = ($urandom_range(99) < gnt_pct);
        if (pend_q.size() > 0 && pend_q[0].due <= cyc && $urandom_range(99) < rsp_pct) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_q[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        inst_ready   = ($urandom_range(99) < rdy_pct);
        redirect     = req_redirect || ($urandom_range(999) < redir_permil);
        redirect_pc  = req_redirect ? req_target : $urandom;
        req_redirect = 1'b0;

        @(negedge clk);
        exp_req = ((fifo_q.size() + pend_q.size()) < DEPTH) && !redirect;
        check_eq("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        if (exp_req) check_eq("imem_addr", imem_addr, exp_fetch_pc);
        rsp_kept = 1'b0;
        rsp_addr = '0;
        if (imem_rvalid) begin
            rsp_addr = pend_q[0].addr;
            rsp_kept = (pend_q[0].epoch == epoch) && !redirect;
        end
        bypass = 1'b0;
`ifdef TRV32I_FETCH_BYPASS_EN
        bypass = rsp_kept && (fifo_q.size() == 0);
`endif
        exp_valid = (fifo_q.size() > 0) || bypass;
        head      = (fifo_q.size() > 0) ? fifo_q[0] : rsp_addr;
        check_eq("inst_valid", {31'b0, inst_valid}, {31'b0, exp_valid});
        if (exp_valid) begin
            check_eq("pc", pc, head);
            check_eq("inst", inst, mem_word(head));
        end else begin
            check_eq("pc_idle", pc, 32'd0);
            check_eq("inst_idle", inst, 32'd0);
        end
        if (inst_valid && inst_ready && !redirect) n_consumed++;

        if (imem_rvalid && pend_q.size() > 0) rsp = pend_q.pop_front();
        if (exp_req && imem_gnt) begin
            lat = $urandom_range(lat_max, lat_min);
            pend_q.push_back('{addr: exp_fetch_pc, epoch: epoch, due: cyc + lat});
            exp_fetch_pc += 32'd4;
            grant_cnt++;
        end
        if (redirect) begin
            fifo_q.delete();
            epoch++;
            exp_fetch_pc = redirect_pc & ~32'd3;
        end else begin
            consumed_bypass = 1'b0;
            if (exp_valid && inst_ready) begin
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                else consumed_bypass = 1'b1;
            end
            if (rsp_kept && !consumed_bypass) fifo_q.push_back(rsp_addr);
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_knobs(input int g, input int r, input int d, input int rd, input int lmin, input int lmax);
        gnt_pct = g; rsp_pct = r; rdy_pct = d; redir_permil = rd; lat_min = lmin; lat_max = lmax;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; epoch = 0; grant_cnt = 0; n_consumed = 0;
        req_redirect = 1'b0; req_target = '0; exp_fetch_pc = RESET_PC;
        set_knobs(100, 100, 0, 0, 1, 1);
        do_reset();

        // Core stalled: exactly DEPTH grants, then the FIFO is full and fetching stops
        grant_cnt = 0;
        repeat (12) step();
        check_eq("stall_grants", grant_cnt, DEPTH);
        check_eq("stall_valid", {31'b0, inst_valid}, 32'd1);
        check_eq("stall_head_pc", pc, RESET_PC);

        // Release ready, then measure steady-state throughput
        set_knobs(100, 100, 100, 0, 1, 1);
        repeat (12) step();
        n_consumed = 0;
        repeat (20) step();
        check_eq("throughput", n_consumed, 20);

        // Latency 3 with requests in flight, redirect to 0x100
        set_knobs(100, 100, 100, 0, 3, 3);
        repeat (10) step();
        req_redirect = 1'b1; req_target = 32'h0000_0100;
        repeat (12) step();

        // Redirect while a response lands and the head is consumed; low bits ignored
        set_knobs(100, 100, 100, 0, 1, 1);
        repeat (8) step();
        req_redirect = 1'b1; req_target = 32'h0000_0203;
        repeat (10) step();

        // Address wrap past 0xFFFF_FFFC
        req_redirect = 1'b1; req_target = 32'hFFFF_FFF4;
        repeat (12) step();

        // Randomized traffic with occasional redirects
        set_knobs(70, 70, 60, 20, 1, 4);
        repeat (1500) step();

        // Asynchronous reset mid-stream, then more random traffic
        do_reset();
        repeat (4) step();
        set_knobs(80, 75, 70, 15, 1, 3);
        repeat (500) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
